// File: rtl/swap_frame_sequencer.sv
// Frame sequencer around the combinational swap stage: gathers an A/B/C frame from a beat
// stream, presents registered operands to the swap stage, and holds the swapped result.
//
// state  | meaning
// LOAD_A | waiting for a frame-start beat (operand A)
// LOAD_B | waiting for operand B
// LOAD_C | waiting for operand C
// SWAP   | operands stable, capture swap stage output
// HOLD   | result valid, waiting for downstream accept
module swap_frame_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     sw_a,
  output logic [W-1:0]     sw_b,
  output logic [W-1:0]     sw_c,
  input  logic [W-1:0]     sw_a1,
  input  logic [W-1:0]     sw_b1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [W-1:0]     out_c,
  output logic             resync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] LOAD_C = 3'd2;
  localparam logic [2:0] SWAP   = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] state;
  logic       accept;

  assign in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      sw_a       <= '0;
      sw_b       <= '0;
      sw_c       <= '0;
      resync_err <= 1'b0;
    end else begin
      resync_err <= 1'b0;
      case (state)
        LOAD_A: begin
          if (accept) begin
            if (in_first) begin
              sw_a  <= in_data;
              state <= LOAD_B;
            end else begin
              resync_err <= 1'b1;
            end
          end
        end
        LOAD_B, LOAD_C: begin
          if (accept) begin
            if (in_first) begin
              // New frame start mid-frame: restart with this beat as A.
              sw_a       <= in_data;
              resync_err <= 1'b1;
              state      <= LOAD_B;
            end else if (state == LOAD_B) begin
              sw_b  <= in_data;
              state <= LOAD_C;
            end else begin
              sw_c  <= in_data;
              state <= SWAP;
            end
          end
        end
        SWAP: state <= HOLD;
        HOLD: if (out_valid && out_ready) state <= LOAD_A;
        default: state <= LOAD_A;
      endcase
    end
  end

  // Result side; out_c comes from our own C register, not the swap stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (state == SWAP) begin
        out_a     <= sw_a1;
        out_b     <= sw_b1;
        out_c     <= sw_c;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_valid && out_ready) begin
        out_valid <= 1'b0;
        frame_cnt <= frame_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_swap_frame_sequencer.sv
// Bench for swap_frame_sequencer: fixed vector table, hand sequences for backpressure,
// wrap and reset, and randomized traffic checked against a frame-level model.
module tb_swap_frame_sequencer;
  localparam int W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, resync_err;
  logic [W-1:0] sw_a, sw_b, sw_c, sw_a1, sw_b1, out_a, out_b, out_c;
  logic [CNT_W-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Swap stage stand-in: a1 carries B, b1 carries A.
  assign sw_a1 = sw_b;
  assign sw_b1 = sw_a;

  swap_frame_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_data(in_data),
    .sw_a(sw_a), .sw_b(sw_b), .sw_c(sw_c), .sw_a1(sw_a1), .sw_b1(sw_b1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .resync_err(resync_err), .frame_cnt(frame_cnt)
  );

  // Frame-level reference: list of operands collected so far plus a busy phase.
  logic [W-1:0] part[$];
  logic [W-1:0] m_sw[3];
  int           m_phase;   // 0 collecting, 1 result being formed, 2 result offered
  logic [W-1:0] m_a, m_b, m_c;
  logic         m_valid, m_err;
  int           m_cnt;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    for (int i = 0; i < 3; i++) m_sw[i] = '0;
    m_phase = 0; m_a = '0; m_b = '0; m_c = '0;
    m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    m_err = 1'b0;
    if (m_phase == 0) begin
      if (in_valid) begin
        if (in_first) begin
          if (part.size() > 0) m_err = 1'b1;
          part.delete();
          part.push_back(in_data);
          m_sw[0] = in_data;
        end else if (part.size() == 0) begin
          m_err = 1'b1;
        end else begin
          m_sw[part.size()] = in_data;
          part.push_back(in_data);
          if (part.size() == 3) m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_a = m_sw[1]; m_b = m_sw[0]; m_c = m_sw[2];
      m_valid = 1'b1;
      part.delete();
      m_phase = 2;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
      m_phase = 0;
    end
  endtask

  task automatic compare_model();
    chk("in_ready", in_ready, (m_phase == 0) ? 1 : 0);
    chk("out_valid", out_valid, m_valid);
    chk("resync_err", resync_err, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_c", out_c, m_c);
    chk("sw_a", sw_a, m_sw[0]);
    chk("sw_b", sw_b, m_sw[1]);
    chk("sw_c", sw_c, m_sw[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1);
    compare_model();
  endtask

  typedef struct {
    logic v, f; logic [3:0] d; logic ordy;
    logic rdy, err, val; logic [3:0] a, b, c; logic [7:0] cnt;
  } vec_t;
  vec_t tbl[14];

  int handoffs;
  int pos;

  initial begin
    // v f  d  ordy | rdy err val  a  b  c  cnt   (values after the edge)
    tbl[0]  = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 4'd3, 4'd5, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[5]  = '{1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[7]  = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[9]  = '{1'b1, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[10] = '{1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 4'd3, 4'd5, 8'd1};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd7, 4'd4, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 4'd7, 4'd4, 8'd2};

    do_reset();

    // Basic frame, orphan beat, resync
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].v; in_first = tbl[i].f; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d_rdy", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_err", i), resync_err, tbl[i].err);
      chk($sformatf("vec%0d_val", i), out_valid, tbl[i].val);
      chk($sformatf("vec%0d_a", i), out_a, tbl[i].a);
      chk($sformatf("vec%0d_b", i), out_b, tbl[i].b);
      chk($sformatf("vec%0d_c", i), out_c, tbl[i].c);
      chk($sformatf("vec%0d_cnt", i), frame_cnt, tbl[i].cnt);
    end

    // Backpressure: hold for 10 cycles while upstream keeps offering beats
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b1; in_data = 4'd3; tick();
    in_first = 1'b0; in_data = 4'd9; tick();
    in_data = 4'd5; tick();
    in_valid = 1'b0; tick();
    chk("bp_valid_start", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_first = i[0]; in_data = 4'hf;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_a", out_a, 9);
      chk("bp_out_b", out_b, 3);
      chk("bp_out_c", out_c, 5);
      chk("bp_cnt", frame_cnt, 2);
      chk("bp_sw_a", sw_a, 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_cnt", frame_cnt, 3);
    chk("bp_release_valid", out_valid, 0);

    // Wrap: 256 back-to-back frames from reset
    do_reset();
    handoffs = 0; pos = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256 * 5; i++) begin
      in_first = (part.size() == 0) && (m_phase == 0);
      in_data = W'($urandom_range(0, 15));
      if (out_valid && out_ready) handoffs++;
      tick();
    end
    chk("wrap_cnt", frame_cnt, 0);
    chk("wrap_handoffs", handoffs + ((out_valid && out_ready) ? 1 : 0), 256);
    in_valid = 1'b0;
    tick();
    chk("wrap_after_cnt", frame_cnt, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if (part.size() == 0) in_first = ($urandom_range(0, 9) != 0);
      else in_first = ($urandom_range(0, 9) == 0);
      in_data = W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset during HOLD
    in_valid = 1'b0; out_ready = 1'b0;
    pos = 0;
    while (!(m_phase == 0 && part.size() == 0) && pos < 20) begin
      if (m_phase == 2) out_ready = 1'b1;
      tick(); pos++;
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b1; in_data = 4'd2; tick();
    in_first = 1'b0; in_data = 4'd11; tick();
    in_data = 4'd13; tick();
    in_valid = 1'b0; tick();
    chk("rst_pre_valid", out_valid, 1);
    chk("rst_pre_a", out_a, 11);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_a", out_a, 0);
    chk("rst_async_b", out_b, 0);
    chk("rst_async_c", out_c, 0);
    chk("rst_async_cnt", frame_cnt, 0);
    chk("rst_async_sw_a", sw_a, 0);
    model_reset();
    #1 rst_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);
    tick();
    chk("rst_after_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
